// File: rtl/task_answer_arbiter.sv
// task_answer_arbiter
//   Shares the single task-manager answer channel between NUM_REQ task output blocks.
//   One requester is granted per packet in round-robin order. Its data, last and
//   latched size are muxed to the manager, and the manager ready goes back to it alone.
//   The grant is released on last or on abort (answer-ready dropped mid-packet).
//   After a last beat or an abort, the arbiter spends one RELEASE cycle before
//   returning to IDLE.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_tanswer_ready     per-requester packet-available flag
//   i_req_tdata             per-requester data, requester r at [r*DATA_WIDTH +: DATA_WIDTH]
//   i_req_tlast             per-requester last-beat flag
//   i_req_packet_size       per-requester packet size, packed like i_req_tdata
//   o_req_tmanager_ready    manager ready, routed to the granted requester only
//   i_tmanager_ready        manager takes a beat this cycle
//   o_tanswer_ready         granted packet available (XFER)
//   o_tdata, o_tanswer_data_last  granted requester's data / last
//   o_packet_size_in_bytes  size latched at grant, 0 outside XFER
//   o_grant                 one-hot grant, 0 when not in XFER
//   o_busy                  high in XFER and RELEASE
//   o_len_err               one-cycle pulse in RELEASE on length mismatch or abort
module task_answer_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SIZE_WIDTH = 12
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_REQ-1:0]               i_req_tanswer_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_tdata,
  input  logic [NUM_REQ-1:0]               i_req_tlast,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0]    i_req_packet_size,
  output logic [NUM_REQ-1:0]               o_req_tmanager_ready,
  input  logic                             i_tmanager_ready,
  output logic                             o_tanswer_ready,
  output logic [DATA_WIDTH-1:0]            o_tdata,
  output logic                             o_tanswer_data_last,
  output logic [SIZE_WIDTH-1:0]            o_packet_size_in_bytes,
  output logic [NUM_REQ-1:0]               o_grant,
  output logic                             o_busy,
  output logic                             o_len_err
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SumW = SIZE_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StXfer, StRelease} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [SIZE_WIDTH-1:0] cnt_q, cnt_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic                  err_pend_q, err_pend_d;

  logic                  pick_found;
  logic [IdxW-1:0]       pick_idx;
  logic [SIZE_WIDTH-1:0] pick_size;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic                  sel_rdy;
  logic [SumW-1:0]       cnt_sum;
  logic                  xfer;

  // Round-robin pick: first requester at or above the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_size  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!pick_found && i_req_tanswer_ready[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(idx);
        pick_size  = i_req_packet_size[idx*SIZE_WIDTH +: SIZE_WIDTH];
      end
    end
  end

  // Granted-requester mux.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_rdy  = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant_q == IdxW'(r)) begin
        sel_data = i_req_tdata[r*DATA_WIDTH +: DATA_WIDTH];
        sel_last = i_req_tlast[r];
        sel_rdy  = i_req_tanswer_ready[r];
      end
    end
  end

  // One extra bit so a saturated counter plus the final beat never aliases a legal size.
  assign cnt_sum = {1'b0, cnt_q} + SumW'(i_tmanager_ready);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    err_pend_d = err_pend_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          size_d     = pick_size;
          cnt_d      = '0;
          err_pend_d = 1'b0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        if (i_tmanager_ready && (cnt_q != '1)) begin
          cnt_d = cnt_q + SIZE_WIDTH'(1);
        end
        // Last wins over a simultaneous abort.
        if (sel_last) begin
          err_pend_d = (cnt_sum != {1'b0, size_q});
          size_d     = '0;
          state_d    = StRelease;
        end else if (!sel_rdy) begin
          err_pend_d = 1'b1;
          size_d     = '0;
          state_d    = StRelease;
        end
      end
      StRelease: begin
        ptr_d      = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + IdxW'(1);
        err_pend_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign xfer = (state_q == StXfer);

  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      o_grant[r]              = xfer && (grant_q == IdxW'(r));
      o_req_tmanager_ready[r] = xfer && (grant_q == IdxW'(r)) && i_tmanager_ready;
    end
  end

  assign o_tanswer_ready        = xfer;
  assign o_tdata                = xfer ? sel_data : '0;
  assign o_tanswer_data_last    = xfer && sel_last;
  assign o_packet_size_in_bytes = size_q;
  assign o_busy                 = (state_q != StIdle);
  assign o_len_err              = (state_q == StRelease) && err_pend_q;

endmodule

// File: tb/tb_task_answer_arbiter.sv
// Self-checking bench for task_answer_arbiter: behavioural requesters, an expected-phase
// tracker and a scoreboard of expected packets and data beats.
module tb_task_answer_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_rdy, req_last, o_req_mgr, o_grant;
  logic [N*DW-1:0] req_data;
  logic [N*SW-1:0] req_size;
  logic            mgr;
  logic            o_tready, o_last, o_busy, o_len_err;
  logic [DW-1:0]   o_tdata;
  logic [SW-1:0]   o_psize;

  always #5 clk = ~clk;

  task_answer_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_req_tanswer_ready   (req_rdy),
    .i_req_tdata           (req_data),
    .i_req_tlast           (req_last),
    .i_req_packet_size     (req_size),
    .o_req_tmanager_ready  (o_req_mgr),
    .i_tmanager_ready      (mgr),
    .o_tanswer_ready       (o_tready),
    .o_tdata               (o_tdata),
    .o_tanswer_data_last   (o_last),
    .o_packet_size_in_bytes(o_psize),
    .o_grant               (o_grant),
    .o_busy                (o_busy),
    .o_len_err             (o_len_err)
  );

  typedef struct {int req; int size; bit err;} pkt_t;
  typedef enum int {PhIdle, PhXfer, PhRel} ph_e;

  pkt_t          pkt_q[$];
  logic [DW-1:0] beat_q[$];
  pkt_t          cur;
  ph_e           phase, last_ph;
  bit            pkt_open;
  int            checks = 0;
  int            errors = 0;

  // Requester model state.
  int act[N], psize[N], nb[N], drop[N], sent[N], pkts[N];
  bit acc[N], ended[N];
  bit tog, sz_glitch;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dval(input int r, input int k);
    return DW'(r * 40 + k * 3 + 1);
  endfunction

  function automatic logic [N-1:0] onehot(input int r);
    logic [N-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic exp_pkt(input int r, input int size, input int beats, input bit err);
    pkt_t p;
    p.req  = r;
    p.size = size;
    p.err  = err;
    pkt_q.push_back(p);
    for (int k = 0; k < beats; k++) beat_q.push_back(dval(r, k));
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      req_rdy[r]              = (act[r] != 0);
      req_data[r*DW +: DW]    = dval(r, sent[r]);
      req_size[r*SW +: SW]    = SW'(psize[r]);
      req_last[r]             = (act[r] != 0) && ((nb[r] == 0) || ((sent[r] == nb[r] - 1) && mgr));
    end
  endtask

  task automatic set_req(input int r, input int size, input int n, input int dr, input int np);
    psize[r] = size;
    nb[r]    = n;
    drop[r]  = dr;
    sent[r]  = 0;
    pkts[r]  = np;
    act[r]   = 1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_tready"}, o_tready, 0);
    check_eq({tag, "_grant"}, o_grant, 0);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_len_err"}, o_len_err, 0);
    check_eq({tag, "_size"}, o_psize, 0);
    check_eq({tag, "_tdata"}, o_tdata, 0);
    check_eq({tag, "_last"}, o_last, 0);
    check_eq({tag, "_mgr_route"}, o_req_mgr, 0);
  endtask

  // Sampled at negedge: compare DUT outputs with the expected phase and scoreboard.
  task automatic observe();
    last_ph = phase;
    for (int r = 0; r < N; r++) begin
      acc[r]   = 1'b0;
      ended[r] = 1'b0;
    end
    case (phase)
      PhIdle: begin
        check_eq("idle_busy", o_busy, 0);
        check_eq("idle_tready", o_tready, 0);
        check_eq("idle_grant", o_grant, 0);
        check_eq("idle_len_err", o_len_err, 0);
        if (|req_rdy) phase = PhXfer;
      end
      PhXfer: begin
        if (!pkt_open) begin
          check_eq("pkt_expected", pkt_q.size() > 0, 1);
          if (pkt_q.size() > 0) cur = pkt_q.pop_front();
          pkt_open = 1'b1;
        end
        check_eq("xfer_tready", o_tready, 1);
        check_eq("xfer_busy", o_busy, 1);
        check_eq("xfer_grant", o_grant, onehot(cur.req));
        check_eq("xfer_size", o_psize, cur.size);
        check_eq("xfer_len_err", o_len_err, 0);
        check_eq("mgr_route", o_req_mgr, mgr ? onehot(cur.req) : {N{1'b0}});
        check_eq("last_mux", o_last, req_last[cur.req]);
        if (mgr && req_rdy[cur.req]) begin
          acc[cur.req] = 1'b1;
          check_eq("beat_expected", beat_q.size() > 0, 1);
          if (beat_q.size() > 0) check_eq("data", o_tdata, beat_q.pop_front());
        end
        if (req_last[cur.req]) begin
          ended[cur.req] = 1'b1;
          phase          = PhRel;
        end else if (!req_rdy[cur.req]) begin
          phase = PhRel;
        end
      end
      default: begin
        check_eq("rel_busy", o_busy, 1);
        check_eq("rel_tready", o_tready, 0);
        check_eq("rel_grant", o_grant, 0);
        check_eq("rel_size", o_psize, 0);
        check_eq("rel_mgr_route", o_req_mgr, 0);
        check_eq("rel_len_err", o_len_err, cur.err);
        pkt_open = 1'b0;
        phase    = PhIdle;
      end
    endcase
  endtask

  task automatic advance();
    for (int r = 0; r < N; r++) begin
      if (ended[r]) begin
        sent[r] = 0;
        pkts[r]--;
        if (pkts[r] <= 0) act[r] = 0;
      end else if (acc[r]) begin
        sent[r]++;
        if (drop[r] >= 0 && sent[r] == drop[r]) act[r] = 0;
      end
      if (sz_glitch && r == 2 && sent[r] == 3) psize[r] = 99;
    end
    if (tog) mgr = ~mgr;
    drive();
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic run(input int budget);
    bit done;
    bit any;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      any = 1'b0;
      for (int r = 0; r < N; r++) if (act[r] != 0) any = 1'b1;
      done = (pkt_q.size() == 0) && (last_ph == PhIdle) && (phase == PhIdle) && !any;
    end
    check_eq("run_done", done, 1);
    check_eq("beats_left", beat_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int r = 0; r < N; r++) begin
      act[r]  = 0;
      sent[r] = 0;
      psize[r] = 0;
      nb[r]   = 1;
      drop[r] = -1;
      pkts[r] = 0;
    end
    mgr       = 1'b0;
    tog       = 1'b0;
    sz_glitch = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    pkt_q.delete();
    beat_q.delete();
    phase    = PhIdle;
    pkt_open = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mgr = 1'b0;
    phase = PhIdle;
    last_ph = PhIdle;
    pkt_open = 1'b0;

    // Single requester 1, 81 beats, then 0 and 2 together: pointer at 2 picks 2 first.
    do_reset();
    mgr = 1'b1;
    set_req(1, 81, 81, -1, 1);
    exp_pkt(1, 81, 81, 0);
    drive();
    run(200);
    set_req(0, 2, 2, -1, 1);
    set_req(2, 2, 2, -1, 1);
    exp_pkt(2, 2, 2, 0);
    exp_pkt(0, 2, 2, 0);
    drive();
    run(50);

    // All four continuously requesting: order 0,1,2,3,0.
    do_reset();
    mgr = 1'b1;
    set_req(0, 3, 3, -1, 2);
    for (int r = 1; r < N; r++) set_req(r, 3, 3, -1, 1);
    exp_pkt(0, 3, 3, 0);
    exp_pkt(1, 3, 3, 0);
    exp_pkt(2, 3, 3, 0);
    exp_pkt(3, 3, 3, 0);
    exp_pkt(0, 3, 3, 0);
    drive();
    run(100);

    // Requester 2, toggling manager ready, size input changed mid-packet.
    do_reset();
    mgr       = 1'b1;
    tog       = 1'b1;
    sz_glitch = 1'b1;
    set_req(2, 10, 10, -1, 1);
    exp_pkt(2, 10, 10, 0);
    drive();
    run(100);
    tog       = 1'b0;
    sz_glitch = 1'b0;

    // Short packet: 7 beats against size 10, then 0 and 1 together -> 1 first.
    do_reset();
    mgr = 1'b1;
    set_req(0, 10, 7, -1, 1);
    exp_pkt(0, 10, 7, 1);
    drive();
    run(50);
    set_req(0, 2, 2, -1, 1);
    set_req(1, 2, 2, -1, 1);
    exp_pkt(1, 2, 2, 0);
    exp_pkt(0, 2, 2, 0);
    drive();
    run(50);

    // Abort by requester 3 after 4 of 8 beats, then 1 and 3 together -> 1 then 3.
    do_reset();
    mgr = 1'b1;
    set_req(3, 8, 8, 4, 1);
    exp_pkt(3, 8, 4, 1);
    drive();
    run(50);
    set_req(1, 2, 2, -1, 1);
    set_req(3, 2, 2, -1, 1);
    exp_pkt(1, 2, 2, 0);
    exp_pkt(3, 2, 2, 0);
    drive();
    run(50);

    // Size 0 with last and no accepted beat: no error.
    do_reset();
    mgr = 1'b0;
    set_req(1, 0, 0, -1, 1);
    exp_pkt(1, 0, 0, 0);
    drive();
    run(20);

    // Asynchronous reset in the middle of a packet, then 0 and 2 together -> 0 first.
    do_reset();
    mgr = 1'b1;
    set_req(2, 10, 10, -1, 1);
    exp_pkt(2, 10, 10, 0);
    drive();
    for (int c = 0; c < 30 && sent[2] != 5; c++) step();
    check_eq("reach_beat5", sent[2], 5);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    do_reset();
    mgr = 1'b1;
    set_req(0, 2, 2, -1, 1);
    set_req(2, 2, 2, -1, 1);
    exp_pkt(0, 2, 2, 0);
    exp_pkt(2, 2, 2, 0);
    drive();
    run(50);

    check_eq("pkt_q_final", pkt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
